sdram_arbiter: RTL and testbench
================================

Name: sdram_arbiter

Overview:
Shares the single sdram_controller request port among NUM_PORTS requesters (VGA line fetch, SD-card loader, joypad/CPU debug). Each requester sees a copy of the controller's req/wr/ack interface. The arbiter selects one requester, latches its command and forwards it to the controller. It holds the grant until the controller acks, then releases the grant and advances round-robin priority. It sits between the requesters and sdram_controller and runs in the sdram_clock domain.

Parameters:
NUM_PORTS, 3, number of requesters (2..8)
ADDR_W, 24, SDRAM word address width
DATA_W, 16, data width
BURST_W, 9, burst length field width

Ports:
clk  input  1  sdram_clock
res  input  1  asynchronous active-high reset
req  input  NUM_PORTS  per-port request; must be held until that port's ack
wr  input  NUM_PORTS  per-port write(1)/read(0)
addr  input  NUM_PORTS*ADDR_W  packed per-port address; port i uses bits [i*ADDR_W +: ADDR_W]
burst  input  NUM_PORTS*BURST_W  packed per-port burst length
data_in  input  NUM_PORTS*DATA_W  packed per-port write data
ack  output  NUM_PORTS  one-cycle completion pulse to the granted port
grant  output  NUM_PORTS  one-hot; high while that port owns the controller
data_out  output  DATA_W  broadcast of mem_data_out
mem_req  output  1  to controller req
mem_wr  output  1  to controller wr
mem_addr  output  ADDR_W  to controller addr_in
mem_burst  output  BURST_W  to controller burst
mem_data_in  output  DATA_W  to controller data_in
mem_data_out  input  DATA_W  from controller data_out
mem_ack  input  1  from controller ack

Behaviour:
- Reset (async, res=1): state=IDLE; ack=0, grant=0, mem_req=0, mem_wr=0, mem_addr=0, mem_burst=0; rr pointer=0. Reset mid-transaction aborts it silently, with no ack. sdram_controller shares res.
- FSM states: IDLE, WAIT, RELEASE.
- IDLE: at edge k with req!=0, the picker selects a winner w.
  - Registers grant=onehot(w), mem_req=1, mem_wr=wr[w], mem_addr=addr[w], mem_burst=burst[w].
  - Next state is WAIT. mem_req is visible the cycle after req is first sampled (latency 1).
  - With req==0 the FSM stays in IDLE and all outputs hold.
- WAIT: the command registers are frozen; later changes to a requester's addr/wr/burst are ignored.
  - At the edge where mem_ack=1: mem_req<=0, ack[w]<=1, next state RELEASE.
  - If mem_ack and res occur together, res wins.
- RELEASE: lasts exactly one cycle.
  - ack<=0, grant<=0, pointer<=(w+1) mod NUM_PORTS, next state IDLE.
  - This cycle prevents the acked port's still-high req from being resampled. A port that reasserts req immediately gets next-round priority only.
- mem_data_in = data_in[w] combinationally, selected by the latched index, during WAIT and RELEASE; 0 in IDLE. This lets write-burst data stream from the owner.
- data_out = mem_data_out, unregistered, to all ports. Only the port with grant high may consume it.
- Picker (round-robin): scan indices pointer, pointer+1, … with wrap-around; the first asserted req wins.
- A req dropped before ack violates the protocol. The arbiter ignores the drop and completes the transaction normally.
- Simultaneous requests are served in rotation. No port waits more than NUM_PORTS-1 transactions.
- Grant is always one-hot or zero, and it changes only in IDLE→WAIT and RELEASE→IDLE.

Optional Feature:
SDRAM_ARB_FIXED_PRIO_EN
- Defined: the picker ignores the pointer, and the lowest-index asserted req always wins (port 0 = VGA, strict priority). The pointer register is removed.
- Undefined: round-robin as described in Behaviour.
- Everything else is identical in both builds.

Decomposition:
- Package sdram_arb_pkg:
  - width constants ADDR_W/DATA_W/BURST_W defaults
  - state encoding localparams ST_IDLE=2'd0, ST_WAIT=2'd1, ST_RELEASE=2'd2
  - macro-free helper for onehot encode
- Sub-module sdram_arb_picker:
  - combinational rotating priority picker
  - inputs: req vector, pointer
  - outputs: winner index and valid
  - holds the SDRAM_ARB_FIXED_PRIO_EN variant

Test Plan:
- Reset: res=1 mid-WAIT with mem_req=1 -> next sample mem_req=0, grant=0, ack=0; after release, port 1 req -> grant=3'b010 after 1 cycle.
- Single read: port 2 req, wr=0, addr=24'h000100, burst=9'd8 -> next cycle mem_req=1, mem_addr=24'h000100, mem_burst=8, grant=3'b100; mem_ack at cycle 5 -> ack[2]=1 cycle 6 only, grant=0 cycle 7.
- Round-robin: req=3'b111 held, each mem_ack 3 cycles after mem_req -> grant sequence 001,010,100,001; no port granted twice consecutively.
- Back-to-back same port: port 0 keeps req high after ack -> no second grant until RELEASE passes; with port 1 also requesting, port 1 wins next.
- Write streaming: port 1 write addr=24'h000200, burst=9'h1FF, data_in[1]=16'h5678 -> mem_wr=1, mem_data_in=16'h5678 throughout WAIT; change addr[1] mid-WAIT -> mem_addr unchanged.
- SDRAM_ARB_FIXED_PRIO_EN defined, req=3'b110 then 3'b111 continuously -> port 1 granted first, then port 0 every round, port 2 never while port 0/1 request.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared constants, FSM state encoding and one-hot helper for the SDRAM request arbiter.
package sdram_arb_pkg;

  localparam int unsigned ADDR_W_DEF  = 24;
  localparam int unsigned DATA_W_DEF  = 16;
  localparam int unsigned BURST_W_DEF = 9;
  localparam int unsigned MAX_PORTS   = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  // Index to one-hot over the largest supported port count; callers truncate.
  function automatic logic [MAX_PORTS-1:0] onehot(input logic [2:0] idx);
    onehot = MAX_PORTS'(1) << idx;
  endfunction

endpackage

// File: rtl/sdram_arb_picker.sv
// Combinational requester picker: rotating priority from ptr, or strict lowest-index
// priority when SDRAM_ARB_FIXED_PRIO_EN is defined (ptr port then disappears).
module sdram_arb_picker
  import sdram_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 3,
  parameter int unsigned IDX_W     = 2
) (
  input  logic [NUM_PORTS-1:0] req,
`ifdef SDRAM_ARB_FIXED_PRIO_EN
`else
  input  logic [IDX_W-1:0]     ptr,
`endif
  output logic [IDX_W-1:0]     win_idx_c,
  output logic                 win_valid_c
);

  int unsigned cand;

  // First asserted request in scan order wins.
  always_comb begin : pick
    win_valid_c = 1'b0;
    win_idx_c   = '0;
    cand        = 0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
      cand = k;
`else
      cand = (32'(ptr) + k) % NUM_PORTS;
`endif
      if (!win_valid_c && req[IDX_W'(cand)]) begin
        win_valid_c = 1'b1;
        win_idx_c   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Shares one sdram_controller request port among NUM_PORTS requesters, holding the grant
// until mem_ack. Build option SDRAM_ARB_FIXED_PRIO_EN selects strict port-0-first priority.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 3,
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned BURST_W   = BURST_W_DEF
) (
  input  logic                         clk,
  input  logic                         res,
  input  logic [NUM_PORTS-1:0]         req,
  input  logic [NUM_PORTS-1:0]         wr,
  input  logic [NUM_PORTS*ADDR_W-1:0]  addr,
  input  logic [NUM_PORTS*BURST_W-1:0] burst,
  input  logic [NUM_PORTS*DATA_W-1:0]  data_in,
  output logic [NUM_PORTS-1:0]         ack,
  output logic [NUM_PORTS-1:0]         grant,
  output logic [DATA_W-1:0]            data_out,
  output logic                         mem_req,
  output logic                         mem_wr,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [BURST_W-1:0]           mem_burst,
  output logic [DATA_W-1:0]            mem_data_in,
  input  logic [DATA_W-1:0]            mem_data_out,
  input  logic                         mem_ack
);

  localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       sel_q, sel_d;
  logic [NUM_PORTS-1:0]   grant_q, grant_d;
  logic [NUM_PORTS-1:0]   ack_q, ack_d;
  logic                   mem_req_q, mem_req_d;
  logic                   mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
  logic [BURST_W-1:0]     mem_burst_q, mem_burst_d;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0]       ptr_q, ptr_d;
`endif

  logic [IDX_W-1:0]       win_idx_c;
  logic                   win_valid_c;
  logic                   win_wr_c;
  logic [ADDR_W-1:0]      win_addr_c;
  logic [BURST_W-1:0]     win_burst_c;

  sdram_arb_picker #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_picker (
    .req         (req),
`ifndef SDRAM_ARB_FIXED_PRIO_EN
    .ptr         (ptr_q),
`endif
    .win_idx_c   (win_idx_c),
    .win_valid_c (win_valid_c)
  );

  // Command fields of the current picker winner.
  always_comb begin : win_mux
    win_wr_c    = 1'b0;
    win_addr_c  = '0;
    win_burst_c = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (win_idx_c == IDX_W'(i)) begin
        win_wr_c    = wr[i];
        win_addr_c  = addr[i*ADDR_W +: ADDR_W];
        win_burst_c = burst[i*BURST_W +: BURST_W];
      end
    end
  end

  // Write data streams live from the owner so bursts can advance word by word.
  always_comb begin : wdata_mux
    mem_data_in = '0;
    if (state_q != ST_IDLE) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        if (sel_q == IDX_W'(i)) begin
          mem_data_in = data_in[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_comb begin : fsm_next
    state_d     = state_q;
    sel_d       = sel_q;
    grant_d     = grant_q;
    ack_d       = ack_q;
    mem_req_d   = mem_req_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_burst_d = mem_burst_q;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
    ptr_d       = ptr_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (win_valid_c) begin
          state_d     = ST_WAIT;
          sel_d       = win_idx_c;
          grant_d     = NUM_PORTS'(onehot(3'(win_idx_c)));
          mem_req_d   = 1'b1;
          mem_wr_d    = win_wr_c;
          mem_addr_d  = win_addr_c;
          mem_burst_d = win_burst_c;
        end
      end
      ST_WAIT: begin
        if (mem_ack) begin
          state_d   = ST_RELEASE;
          mem_req_d = 1'b0;
          ack_d     = grant_q;
        end
      end
      ST_RELEASE: begin
        // One dead cycle keeps the just-acked port's held req from being resampled.
        state_d = ST_IDLE;
        ack_d   = '0;
        grant_d = '0;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
        if (32'(sel_q) == NUM_PORTS - 1) begin
          ptr_d = '0;
        end else begin
          ptr_d = sel_q + IDX_W'(1);
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge res) begin : regs
    if (res) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      grant_q     <= '0;
      ack_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_burst_q <= '0;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
      ptr_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      grant_q     <= grant_d;
      ack_q       <= ack_d;
      mem_req_q   <= mem_req_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_burst_q <= mem_burst_d;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign ack       = ack_q;
  assign grant     = grant_q;
  assign mem_req   = mem_req_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_burst = mem_burst_q;
  assign data_out  = mem_data_out;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: directed scenarios plus randomized traffic against a
// transaction-level arbitration model.
module tb_sdram_arbiter;

  localparam int unsigned NP = 3;
  localparam int unsigned AW = 24;
  localparam int unsigned DW = 16;
  localparam int unsigned BW = 9;

  logic              clk = 1'b0;
  logic              res;
  logic [NP-1:0]     req;
  logic [NP-1:0]     wr;
  logic [NP*AW-1:0]  addr;
  logic [NP*BW-1:0]  burst;
  logic [NP*DW-1:0]  data_in;
  logic [NP-1:0]     ack;
  logic [NP-1:0]     grant;
  logic [DW-1:0]     data_out;
  logic              mem_req;
  logic              mem_wr;
  logic [AW-1:0]     mem_addr;
  logic [BW-1:0]     mem_burst;
  logic [DW-1:0]     mem_data_in;
  logic [DW-1:0]     mem_data_out;
  logic              mem_ack;

  int checks = 0;
  int errors = 0;
  int ptr_m  = 0;

  sdram_arbiter #(
    .NUM_PORTS (NP),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .BURST_W   (BW)
  ) dut (
    .clk          (clk),
    .res          (res),
    .req          (req),
    .wr           (wr),
    .addr         (addr),
    .burst        (burst),
    .data_in      (data_in),
    .ack          (ack),
    .grant        (grant),
    .data_out     (data_out),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_addr     (mem_addr),
    .mem_burst    (mem_burst),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out),
    .mem_ack      (mem_ack)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Arbitration rule: scan from the rotating pointer (or from 0 in fixed priority).
  function automatic int pick(input logic [NP-1:0] r, input int p);
    int s;
    s = p;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    s = 0;
`endif
    for (int k = 0; k < int'(NP); k++) begin
      if (r[(s + k) % NP]) return (s + k) % NP;
    end
    return -1;
  endfunction

  // One full transaction: grant, lat wait cycles, ack, release.
  task automatic serve(input int lat, input logic [NP-1:0] keep);
    int            w;
    logic [NP-1:0] oh;
    logic [AW-1:0] ea;
    logic [BW-1:0] eb;
    logic          ew;
    w = pick(req, ptr_m);
    if (w < 0) return;
    oh = NP'(1) << w;
    ea = addr[w*AW +: AW];
    eb = burst[w*BW +: BW];
    ew = wr[w];
    mem_data_out = DW'($urandom());
    step();
    chk("grant", 32'(grant), 32'(oh));
    chk("mem_req", 32'(mem_req), 32'd1);
    chk("mem_wr", 32'(mem_wr), 32'(ew));
    chk("mem_addr", 32'(mem_addr), 32'(ea));
    chk("mem_burst", 32'(mem_burst), 32'(eb));
    chk("mem_data_in", 32'(mem_data_in), 32'(data_in[w*DW +: DW]));
    chk("data_out", 32'(data_out), 32'(mem_data_out));
    chk("ack_early", 32'(ack), 32'd0);
    for (int c = 0; c < lat; c++) begin
      addr[w*AW +: AW]    = AW'($urandom());
      burst[w*BW +: BW]   = BW'($urandom());
      wr[w]               = ~wr[w];
      data_in[w*DW +: DW] = DW'($urandom());
      #1;
      chk("wdata_live", 32'(mem_data_in), 32'(data_in[w*DW +: DW]));
      step();
      chk("wait_req", 32'(mem_req), 32'd1);
      chk("wait_grant", 32'(grant), 32'(oh));
      chk("wait_addr", 32'(mem_addr), 32'(ea));
      chk("wait_wr", 32'(mem_wr), 32'(ew));
      chk("wait_burst", 32'(mem_burst), 32'(eb));
    end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("ack", 32'(ack), 32'(oh));
    chk("ack_mem_req", 32'(mem_req), 32'd0);
    chk("ack_grant", 32'(grant), 32'(oh));
    req = req & ~(oh & ~keep);
    step();
    chk("rel_ack", 32'(ack), 32'd0);
    chk("rel_grant", 32'(grant), 32'd0);
    chk("idle_wdata", 32'(mem_data_in), 32'd0);
    ptr_m = (w + 1) % NP;
  endtask

  task automatic randomize_fields();
    for (int i = 0; i < int'(NP); i++) begin
      wr[i]               = 1'($urandom());
      addr[i*AW +: AW]    = AW'($urandom());
      burst[i*BW +: BW]   = BW'($urandom());
      data_in[i*DW +: DW] = DW'($urandom());
    end
  endtask

  initial begin
    logic [AW-1:0] held_addr;
    res = 1'b1; req = '0; wr = '0; addr = '0; burst = '0; data_in = '0;
    mem_data_out = '0; mem_ack = 1'b0;
    step();
    step();
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_burst", 32'(mem_burst), 32'd0);
    chk("rst_wdata", 32'(mem_data_in), 32'd0);
    res = 1'b0;
    step();

    // single read from port 2
    addr[2*AW +: AW] = 24'h000100; burst[2*BW +: BW] = 9'd8; wr[2] = 1'b0;
    req = 3'b100;
    serve(4, 3'b000);

    // write streaming from port 1 with mid-WAIT field changes
    addr[1*AW +: AW] = 24'h000200; burst[1*BW +: BW] = 9'h1FF; wr[1] = 1'b1;
    data_in[1*DW +: DW] = 16'h5678;
    req = 3'b010;
    serve(3, 3'b000);

    // idle hold with no requests
    held_addr = mem_addr;
    repeat (3) step();
    chk("idle_req", 32'(mem_req), 32'd0);
    chk("idle_grant", 32'(grant), 32'd0);
    chk("idle_addr_hold", 32'(mem_addr), 32'(held_addr));

    // all ports requesting continuously
    randomize_fields();
    req = 3'b111;
    for (int n = 0; n < 4; n++) serve(3, 3'b111);

    // port 0 keeps requesting, then port 1 joins
    req = 3'b001;
    serve(1, 3'b001);
    req = req | 3'b010;
    serve(1, 3'b001);
    serve(0, 3'b000);

    // fixed-priority shape: 110 then 111 held
    req = 3'b110;
    serve(2, 3'b110);
    req = 3'b111;
    for (int n = 0; n < 3; n++) serve(1, 3'b111);
    req = '0;
    step();

    // reset in the middle of WAIT
    req = 3'b001;
    step();
    chk("pre_rst_mem_req", 32'(mem_req), 32'd1);
    res = 1'b1;
    #1;
    chk("midrst_mem_req", 32'(mem_req), 32'd0);
    chk("midrst_grant", 32'(grant), 32'd0);
    chk("midrst_ack", 32'(ack), 32'd0);
    req = '0;
    step();
    res = 1'b0;
    ptr_m = 0;
    chk("postrst_ack", 32'(ack), 32'd0);
    req = 3'b010;
    serve(1, 3'b000);

    // randomized traffic
    for (int n = 0; n < 80; n++) begin
      randomize_fields();
      req = req | NP'($urandom());
      if (req == '0) req[$urandom_range(NP - 1, 0)] = 1'b1;
      serve(int'($urandom_range(4, 0)), NP'($urandom()));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
